// File: rtl/uart_mmio_bridge.sv
// Load/store MMIO bridge between the CPU datapath and a byte-stream UART.
// Buffers TX/RX bytes in FIFOs and exposes status, data and a cycle counter.
module uart_mmio_bridge #(
   parameter int TX_DEPTH = 8,
   parameter int RX_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] addr,
   input  logic        re,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready
);

   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam logic [TAW:0] TX_ONE = 1;
   localparam logic [RAW:0] RX_ONE = 1;

   localparam logic [7:0] OFF_TXS = 8'h00;
   localparam logic [7:0] OFF_RXS = 8'h04;
   localparam logic [7:0] OFF_TXD = 8'h08;
   localparam logic [7:0] OFF_RXD = 8'h0C;
   localparam logic [7:0] OFF_CNT = 8'h10;

   logic       sel;
   logic [7:0] off;
   logic       re_eff;
   logic       we_eff;
   logic       rd;
   logic       hit_txs;
   logic       hit_rxs;
   logic       hit_txd;
   logic       hit_rxd;
   logic       hit_cnt;
   logic       unused;

   assign sel    = (addr[31:28] == 4'h8) && (addr[1:0] == 2'b00);
   assign off    = addr[7:0];
   assign re_eff = re & ~stall & sel;
   assign we_eff = we & ~stall & sel;
   assign rd     = re_eff & ~we_eff;
   assign unused = ^{addr[27:8], wdata[31:8]};

   assign hit_txs = (off == OFF_TXS);
   assign hit_rxs = (off == OFF_RXS);
   assign hit_txd = (off == OFF_TXD);
   assign hit_rxd = (off == OFF_RXD);
   assign hit_cnt = (off == OFF_CNT);

   logic [7:0]   tx_mem [TX_DEPTH];
   logic [TAW:0] tx_wp;
   logic [TAW:0] tx_rp;
   logic         tx_empty;
   logic         tx_full;
   logic         tx_wr;
   logic         tx_push;
   logic         tx_pop;
   logic         tx_ovf;
   logic         ovf_set;
   logic         ovf_clr;

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) &&
                     (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
   assign tx_wr    = we_eff & hit_txd;
   assign tx_push  = tx_wr & ~tx_full;
   assign ovf_set  = tx_wr & tx_full;
   assign ovf_clr  = rd & hit_txs;
   assign tx_pop   = ~tx_empty & tx_ready;
   assign tx_valid = ~tx_empty;
   assign tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rp[TAW-1:0]];

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= wdata[7:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_wp  <= '0;
         tx_rp  <= '0;
         tx_ovf <= 1'b0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + TX_ONE;
         if (tx_pop)  tx_rp <= tx_rp + TX_ONE;
         // a dropped push must stay visible even if the clearing read lands now
         if (ovf_set)      tx_ovf <= 1'b1;
         else if (ovf_clr) tx_ovf <= 1'b0;
      end
   end

   logic [7:0]   rx_mem [RX_DEPTH];
   logic [RAW:0] rx_wp;
   logic [RAW:0] rx_rp;
   logic         rx_empty;
   logic         rx_full;
   logic         rx_push;
   logic         rx_pop;
   logic [7:0]   rx_head;

   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) &&
                     (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
   assign rx_ready = ~rx_full;
   assign rx_push  = rx_valid & ~rx_full;
   assign rx_pop   = rd & hit_rxd & ~rx_empty;
   assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rp[RAW-1:0]];

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + RX_ONE;
         if (rx_pop)  rx_rp <= rx_rp + RX_ONE;
      end
   end

   logic [31:0] cnt;
   logic [31:0] cnt_nxt;

   assign cnt_nxt = cnt + 32'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  cnt <= '0;
      else if (we_eff & hit_cnt) cnt <= '0;
      else                       cnt <= cnt_nxt;
   end

   logic [31:0] rd_val;

   always_comb begin
      rd_val = '0;
      unique case (1'b1)
         hit_txs: rd_val = {30'b0, tx_ovf, ~tx_full};
         hit_rxs: rd_val = {31'b0, ~rx_empty};
         hit_rxd: rd_val = {24'b0, rx_head};
         hit_cnt: rd_val = cnt;
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        rdata <= '0;
      else if (re_eff) rdata <= rd ? rd_val : 32'h0;
   end

endmodule
